// File: rtl/ndi_seq_ctrl.sv
// Sequencing controller for the normalized-difference index datapath.
// Time-shares one restoring divider across pairs (A,C) then (B,D) and
// presents M/N on a valid/ready output.
// Optional build macro NDI_EARLY_OUT_EN: pairs with d==0 or s==0 skip the
// divider and finish their phase in one edge. Results match either way.
module ndi_seq_ctrl #(
  parameter int unsigned ZERO_DEN_CODE = 8,
  parameter int unsigned SAT_MAX       = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_m,
  output logic [3:0]  out_n,
  output logic [1:0]  out_zden,
  output logic        busy
);

  localparam logic [3:0] ZdCode = 4'(ZERO_DEN_CODE);
  localparam logic [3:0] SatMax = 4'(SAT_MAX);

  typedef enum logic [1:0] {StIdle, StDivAc, StDivBd, StOut} state_e;

  state_e      state_q, state_d;
  logic [3:0]  a_q, b_q, c_q, d_q;
  logic        cap;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  rem_q, rem_d;
  logic [6:0]  quo_q, quo_d;
  logic [3:0]  m_q, m_d, n_q, n_d;
  logic [1:0]  zden_q, zden_d;

  logic [3:0]  x_cur, y_cur;
  logic [4:0]  s_cur;
  logic [5:0]  trial, diff;
  logic        ge;
  logic [4:0]  rem_step;
  logic [6:0]  quo_step;
  logic        early, last;
  logic [3:0]  res;

  // |x-y| * 8 as the 7-bit dividend.
  function automatic logic [6:0] dividend(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ad;
    ad = (x >= y) ? (x - y) : (y - x);
    return {ad, 3'b000};
  endfunction

  // Final 4-bit code from the pair and its quotient (quotient never exceeds 8).
  function automatic logic [3:0] pair_result(input logic [3:0] x, input logic [3:0] y,
                                             input logic [3:0] q);
    logic [4:0] s;
    logic [4:0] r;
    s = {1'b0, x} + {1'b0, y};
    if (s == 5'd0) return ZdCode;
    if (x == y) return 4'd8;
    r = (x > y) ? (5'd8 + {1'b0, q}) : (5'd8 - {1'b0, q});
    if (r > {1'b0, SatMax}) r = {1'b0, SatMax};
    return r[3:0];
  endfunction

  // Current pair operands and one restoring-division step.
  always_comb begin
    x_cur    = (state_q == StDivBd) ? b_q : a_q;
    y_cur    = (state_q == StDivBd) ? d_q : c_q;
    s_cur    = {1'b0, x_cur} + {1'b0, y_cur};
    trial    = {rem_q, quo_q[6]};
    diff     = trial - {1'b0, s_cur};
    ge       = (trial >= {1'b0, s_cur});
    rem_step = ge ? diff[4:0] : trial[4:0];
    quo_step = {quo_q[5:0], ge};
`ifdef NDI_EARLY_OUT_EN
    early    = (x_cur == y_cur);
`else
    early    = 1'b0;
`endif
    last     = (cnt_q == 3'd6) || early;
    res      = pair_result(x_cur, y_cur, quo_step[3:0]);
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    m_d     = m_q;
    n_d     = n_q;
    zden_d  = zden_q;
    cap     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cap     = 1'b1;
          state_d = StDivAc;
          cnt_d   = 3'd0;
          rem_d   = 5'd0;
          quo_d   = dividend(in_data[15:12], in_data[7:4]);
        end
      end
      StDivAc: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 3'd1;
        if (last) begin
          m_d       = res;
          zden_d[0] = (s_cur == 5'd0);
          state_d   = StDivBd;
          cnt_d     = 3'd0;
          rem_d     = 5'd0;
          quo_d     = dividend(b_q, d_q);
        end
      end
      StDivBd: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 3'd1;
        if (last) begin
          n_d       = res;
          zden_d[1] = (s_cur == 5'd0);
          state_d   = StOut;
          cnt_d     = 3'd0;
        end
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, divider and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      rem_q   <= 5'd0;
      quo_q   <= 7'd0;
      m_q     <= 4'd0;
      n_q     <= 4'd0;
      zden_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      m_q     <= m_d;
      n_q     <= n_d;
      zden_q  <= zden_d;
    end
  end

  // Sample capture on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= 4'd0;
      b_q <= 4'd0;
      c_q <= 4'd0;
      d_q <= 4'd0;
    end else if (cap) begin
      a_q <= in_data[15:12];
      b_q <= in_data[11:8];
      c_q <= in_data[7:4];
      d_q <= in_data[3:0];
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StOut);
  assign out_m     = m_q;
  assign out_n     = n_q;
  assign out_zden  = zden_q;

endmodule

// File: tb/tb_ndi_seq_ctrl.sv
// Self-checking bench for ndi_seq_ctrl: directed vectors, backpressure,
// mid-operation reset and random words against an arithmetic reference.
module tb_ndi_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_m;
  logic [3:0]  out_n;
  logic [1:0]  out_zden;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ndi_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_m    (out_m),
    .out_n    (out_n),
    .out_zden (out_zden),
    .busy     (busy)
  );

  // Index from the defining formula: 8 + sign(d) * trunc(8|d|/s), clamped to 15.
  function automatic logic [3:0] ref_idx(input int x, input int y);
    int d, s, q, r;
    d = x - y;
    s = x + y;
    if (s == 0) return 4'd8;
    q = (8 * ((d < 0) ? -d : d)) / s;
    r = (d < 0) ? (8 - q) : (8 + q);
    if (r > 15) r = 15;
    return 4'(r);
  endfunction

  function automatic int ref_lat(input logic [15:0] w);
`ifdef NDI_EARLY_OUT_EN
    int slow;
    slow = 0;
    if (w[15:12] != w[7:4]) slow++;
    if (w[11:8] != w[3:0]) slow++;
    return 2 + 6 * slow;
`else
    return 14;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_m"}, 32'(out_m), 32'd0);
    check({tag, "_n"}, 32'(out_n), 32'd0);
    check({tag, "_zden"}, 32'(out_zden), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // One full transaction: accept, measure latency, hold under backpressure, release.
  task automatic run_txn(input logic [15:0] w, input int hold);
    logic [3:0] em, en;
    logic [1:0] ez;
    int         edges;
    em = ref_idx(int'(w[15:12]), int'(w[7:4]));
    en = ref_idx(int'(w[11:8]), int'(w[3:0]));
    ez = {(w[11:8] == 4'd0) && (w[3:0] == 4'd0), (w[15:12] == 4'd0) && (w[7:4] == 4'd0)};
    edges = 0;
    while (!in_ready && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("idle_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("latency", 32'(edges), 32'(ref_lat(w)));
    check("out_m", 32'(out_m), 32'(em));
    check("out_n", 32'(out_n), 32'(en));
    check("out_zden", 32'(out_zden), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_m", 32'(out_m), 32'(em));
      check("hold_n", 32'(out_n), 32'(en));
      check("hold_zden", 32'(out_zden), 32'(ez));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
    check("keep_m", 32'(out_m), 32'(em));
    check("keep_n", 32'(out_n), 32'(en));
    check("keep_zden", 32'(out_zden), 32'(ez));
  endtask

  initial begin
    logic [15:0] w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 16'h0000;
    #1;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    // Directed vectors from the defining examples.
    run_txn(16'hF00F, 0);
    run_txn(16'h0503, 1);
    run_txn(16'h3752, 5);
    run_txn(16'h4444, 0);
    run_txn(16'h0000, 2);
    run_txn(16'h5A5A, 0);

    // Reset asserted at E6 of a fresh transaction aborts it.
    in_valid = 1'b1;
    in_data  = 16'hF00F;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("after_midop_reset");
    run_txn(16'hF00F, 0);

    // Random words, with equal pairs forced often to exercise d==0 and s==0.
    for (int i = 0; i < 30; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[7:4] = w[15:12];
      if ($urandom_range(0, 3) == 0) w[3:0] = w[11:8];
      if ($urandom_range(0, 7) == 0) w[15:12] = 4'd0;
      if ($urandom_range(0, 7) == 0) w[7:4] = 4'd0;
      run_txn(w, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ndi_seq_ctrl.md
Name: ndi_seq_ctrl

Overview:
- Sequencing controller for the normalized-difference index (NDVI/NDWI/NBR) datapath.
- Accepts one packed word of four 4-bit band samples over a valid/ready handshake.
- Computes both pair indices, (A-C)/(A+C) and (B-D)/(B+D), by time-sharing a single multi-cycle restoring divider, then presents M/N on a valid/ready output.
- Replaces the combinational dual-divider path for area-constrained builds.

Parameters:
- ZERO_DEN_CODE, 8, 4-bit code output for a pair whose sum is 0.
- SAT_MAX, 15, upper clamp applied to each 4-bit result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller can accept a word; high only in IDLE.
- in_data  in  16  {A[15:12], B[11:8], C[7:4], D[3:0]}, unsigned samples.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_m  out  4  index for pair A,C.
- out_n  out  4  index for pair B,D.
- out_zden  out  2  bit0: A+C==0; bit1: B+D==0.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state=IDLE, out_valid=0, out_m=0, out_n=0, out_zden=0, busy=0, in_ready=1 (in_ready is decoded from state).
- Per-pair arithmetic:
  - d = X-Y, signed, range -15..15; s = X+Y, range 0..30.
  - q = trunc_toward_zero(8*|d| / s), range 0..8.
  - r = 8 + sign(d)*q, range 0..16; clamp to SAT_MAX.
  - s==0 gives r=ZERO_DEN_CODE and sets the matching out_zden bit.
- Divider: restoring, 7-bit dividend |8d| (max 120), 5-bit divisor s. One quotient bit per cycle, 7 iterations per pair. Shared by both pairs, AC first.
- States: IDLE -> DIV_AC -> DIV_BD -> OUT -> IDLE.
- Timing, E0 = accepting edge (in_valid & in_ready):
  - E0: all four samples captured; state -> DIV_AC.
  - E1..E7: AC iterations. At E7, out_m and out_zden[0] are registered; state -> DIV_BD.
  - E8..E14: BD iterations. At E14, out_n and out_zden[1] are registered; state -> OUT, so out_valid=1 after E14.
  - Latency: 14 edges from accept to out_valid.
- OUT state:
  - out_valid=1; out_m, out_n, out_zden are stable while out_ready=0.
  - The edge with out_valid & out_ready moves the state to IDLE. out_valid drops and in_ready rises on the next cycle.
  - No same-cycle accept-on-release; minimum input period is 16 cycles.
- out_m, out_n, out_zden hold their last values after the output handshake until overwritten by the next result.
- in_valid in a non-IDLE state is ignored; in_data is not sampled.
- A pair with s==0 still spends its 7 divider cycles; its result is forced to ZERO_DEN_CODE.
- Reset mid-operation: immediate abort, all reset values restored, partial results discarded.

Optional Feature:
- Macro: NDI_EARLY_OUT_EN.
- Defined: a pair with d==0 or s==0 skips the divider and its DIV phase lasts exactly 1 edge.
  - Result: 8 if d==0; ZERO_DEN_CODE if s==0.
  - Latency: both pairs early 2 edges; one pair early 8 edges; neither early 14 edges.
- Undefined: fixed 14-edge latency for every input.
- Results are identical in both builds.

Test Plan:
- in_data=0xF00F (A=15, B=0, C=0, D=15) -> after 14 edges: out_valid=1, out_m=15 (16 clamped), out_n=0, out_zden=0.
- in_data=0x0503 (A=0, B=5, C=0, D=3) -> out_m=8, out_zden=2'b01, out_n=10 (8*2/8=2).
- in_data=0x3752 (A=3, B=7, C=5, D=2) -> out_m=6 (d=-2, s=8), out_n=12 (40/9 truncates to 4).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 for one edge -> out_valid=0 and in_ready=1 on the next cycle.
- Assert rst for 1 cycle at E6 during DIV_AC -> all outputs at reset values immediately. After release, in_data=0xF00F completes normally with M=15, N=0.
- With NDI_EARLY_OUT_EN defined, in_data=0x4444 -> out_valid after 2 edges, M=N=8. Without the macro -> after 14 edges, same values.
